// File: rtl/usb_tx_arbiter.sv
// usb_tx_arbiter
//
// Shares the single USB transmit FIFO write port among up to four packet
// sources. A source raises src_rdy, gets a one-cycle src_ack, then streams one
// framed packet which is copied byte-for-byte into the FIFO one cycle later.
// A grant is only issued when the FIFO can absorb a worst-case packet; a
// packet that stalls for TIMEOUT idle cycles is aborted with err_timeout.
//
// Ports:
//   clk           single clock
//   rst           synchronous reset, active-high
//   src_rdy       per-source packet pending
//   src_ack       one-hot, one-cycle grant pulse
//   src_q         per-source byte, source i on [8i+7:8i]
//   src_valid     per-source byte strobe
//   src_last      per-source end-of-packet flag, qualified by src_valid
//   fifo_wrusedw  FIFO fill level
//   fifo_wrreq    FIFO write strobe
//   fifo_data     FIFO write data
//   busy          high while a grant/transfer is in progress
//   cur_src       granted source index, held after the packet ends
//   err_timeout   one-cycle pulse when a packet is aborted
//
// Build option:
//   USB_TX_ARB_FIXED_PRIO_EN  defined: lowest requesting index always wins.
//                             undefined (default): round-robin after the
//                             previous winner.

module usb_tx_arbiter #(
   parameter int N_SRC   = 4,
   parameter int FIFO_AW = 11,
   parameter int MAX_PKT = 40,
   parameter int TIMEOUT = 63
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_SRC-1:0]     src_rdy,
   output logic [N_SRC-1:0]     src_ack,
   input  logic [8*N_SRC-1:0]   src_q,
   input  logic [N_SRC-1:0]     src_valid,
   input  logic [N_SRC-1:0]     src_last,
   input  logic [FIFO_AW-1:0]   fifo_wrusedw,
   output logic                 fifo_wrreq,
   output logic [7:0]           fifo_data,
   output logic                 busy,
   output logic [1:0]           cur_src,
   output logic                 err_timeout
);

   // state | meaning
   // IDLE  | waiting for a request with enough FIFO space
   // GRANT | one-cycle acknowledge to the winner
   // XFER  | copying the winner's bytes into the FIFO
   typedef enum logic [1:0] {IDLE, GRANT, XFER} state_t;

   state_t             state, state_nx;
   logic [1:0]         last, last_nx, cur_nx, win;
   logic [7:0]         idle_cnt, idle_nx, idle_inc;
   logic [N_SRC-1:0]   ack_nx;
   logic               wrreq_nx, busy_nx, err_nx;
   logic [7:0]         data_nx, sel_q;
   logic               sel_valid, sel_last, space_ok, found;
   logic [FIFO_AW:0]   space;

   assign space    = {1'b0, {FIFO_AW{1'b1}}} - {1'b0, fifo_wrusedw};
   assign space_ok = (space >= (FIFO_AW+1)'(MAX_PKT));
   assign idle_inc = (idle_cnt == 8'hff) ? idle_cnt : idle_cnt + 8'd1;

   // Lane of the currently granted source; every other lane is ignored.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_q     = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (cur_src == 2'(i)) begin
            sel_valid = src_valid[i];
            sel_last  = src_last[i];
            sel_q     = src_q[8*i +: 8];
         end
      end
   end

   always_comb begin
      win   = '0;
      found = 1'b0;
`ifdef USB_TX_ARB_FIXED_PRIO_EN
      for (int i = 0; i < N_SRC; i++) begin
         if (!found && src_rdy[i]) begin
            win   = 2'(i);
            found = 1'b1;
         end
      end
`else
      // Scan last+1, last+2, ... modulo N_SRC; first requester wins.
      for (int k = 1; k <= N_SRC; k++) begin
         for (int i = 0; i < N_SRC; i++) begin
            if (!found && src_rdy[i] && ((int'(last) + k) % N_SRC) == i) begin
               win   = 2'(i);
               found = 1'b1;
            end
         end
      end
`endif
   end

   always_comb begin
      state_nx = state;
      last_nx  = last;
      cur_nx   = cur_src;
      idle_nx  = idle_cnt;
      ack_nx   = '0;
      wrreq_nx = 1'b0;
      data_nx  = fifo_data;
      err_nx   = 1'b0;
      case (state)
         IDLE: begin
            if (|src_rdy && space_ok) begin
               state_nx = GRANT;
               cur_nx   = win;
               for (int i = 0; i < N_SRC; i++) ack_nx[i] = (win == 2'(i));
            end
         end
         GRANT: begin
            state_nx = XFER;
            idle_nx  = '0;
         end
         XFER: begin
            if (sel_valid) begin
               wrreq_nx = 1'b1;
               data_nx  = sel_q;
               idle_nx  = '0;
               if (sel_last) begin
                  last_nx  = cur_src;
                  state_nx = IDLE;
               end
            end else begin
               idle_nx = idle_inc;
               // Abort on the TIMEOUT-th consecutive silent cycle; bytes
               // already written stay in the FIFO.
               if (idle_inc == 8'(TIMEOUT)) begin
                  err_nx   = 1'b1;
                  last_nx  = cur_src;
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
      busy_nx = (state_nx != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         last        <= 2'(N_SRC-1);
         cur_src     <= '0;
         idle_cnt    <= '0;
         src_ack     <= '0;
         fifo_wrreq  <= 1'b0;
         fifo_data   <= '0;
         busy        <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         state       <= state_nx;
         last        <= last_nx;
         cur_src     <= cur_nx;
         idle_cnt    <= idle_nx;
         src_ack     <= ack_nx;
         fifo_wrreq  <= wrreq_nx;
         fifo_data   <= data_nx;
         busy        <= busy_nx;
         err_timeout <= err_nx;
      end
   end

endmodule
